// File: rtl/sdram_cfg_pkg.sv
// Shared definitions for the SDRAM configuration register bank:
// field widths, caddr bit positions and the timing-set record.
package sdram_cfg_pkg;

   localparam int CAS_W     = 2;
   localparam int RC_W      = 2;
   localparam int REFD_W    = 4;
   localparam int BURST_W   = 4;

   // Field positions inside caddr for a timing-set write
   localparam int CAS_LSB   = 0;
   localparam int RC_LSB    = 2;
   localparam int REFD_LSB  = 4;
   localparam int PAGE_BIT  = 8;
   localparam int BURST_LSB = 9;
   localparam int FIELD_MSB = 12;

   typedef struct packed {
      logic [BURST_W-1:0] bur_len;
      logic               page_mod;
      logic [REFD_W-1:0]  ref_dur;
      logic [RC_W-1:0]    ras_cas;
      logic [CAS_W-1:0]   cas_lat;
   } timing_set_t;

   // Unpack the low caddr bits into a timing set; upper bits never reach here
   function automatic timing_set_t decode_timing(input logic [FIELD_MSB:0] raw);
      timing_set_t t;
      t.cas_lat  = raw[CAS_LSB +: CAS_W];
      t.ras_cas  = raw[RC_LSB +: RC_W];
      t.ref_dur  = raw[REFD_LSB +: REFD_W];
      t.page_mod = raw[PAGE_BIT];
      t.bur_len  = raw[BURST_LSB +: BURST_W];
      return t;
   endfunction

endpackage

// File: rtl/sdram_cfg_regs_if.sv
// Configuration bus plus refresh req/ack handshake between the
// host/sequencer side (master) and the register bank (slave).
interface sdram_cfg_regs_if #(
   parameter int PADD_SIZE = 24,
   parameter int CS_W      = 2,
   parameter int PEND_W    = 4
);
   logic                 load_time;
   logic                 load_rfcnt;
   logic                 commit;
   logic [CS_W-1:0]      cs_sel;
   logic [PADD_SIZE-1:0] caddr;
   logic                 ref_ack;
   logic                 ref_req;
   logic                 ref_urgent;
   logic [PEND_W-1:0]    ref_pend;

   modport master (
      output load_time, load_rfcnt, commit, cs_sel, caddr, ref_ack,
      input  ref_req, ref_urgent, ref_pend
   );

   modport slave (
      input  load_time, load_rfcnt, commit, cs_sel, caddr, ref_ack,
      output ref_req, ref_urgent, ref_pend
   );
endinterface

// File: rtl/sdram_ref_timer.sv
// Refresh interval down-counter with a saturating count of postponed
// refreshes and registered req/urgent flags for the command sequencer.
module sdram_ref_timer #(
   parameter int RFC_W    = 16,
   parameter int MAX_PEND = 8,
   parameter int PEND_W   = 4
) (
   input  logic              clk0,
   input  logic              reset,
   input  logic              load_rfcnt,
   input  logic [RFC_W-1:0]  rfc_val,
   input  logic              ref_ack,
   output logic [RFC_W-1:0]  refresh_count,
   output logic              ref_req,
   output logic              ref_urgent,
   output logic [PEND_W-1:0] ref_pend
);

   localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(MAX_PEND);
   localparam logic [PEND_W-1:0] PEND_ZERO = {PEND_W{1'b0}};
   localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
   localparam logic [RFC_W-1:0]  RFC_ZERO  = {RFC_W{1'b0}};
   localparam logic [RFC_W-1:0]  RFC_ONE   = RFC_W'(1);

   logic [RFC_W-1:0]  interval_r;
   logic [RFC_W-1:0]  timer_r;
   logic [RFC_W-1:0]  timer_nxt_s;
   logic              enable_s;
   logic              tick_s;
   logic [PEND_W-1:0] pend_r;
   logic [PEND_W-1:0] pend_nxt_s;
   logic              req_r;
   logic              urgent_r;

   assign enable_s = (interval_r != RFC_ZERO);
   assign tick_s   = enable_s && (timer_r == RFC_ONE);

   // Next timer value: a load restarts the interval, a tick reloads it
   always_comb begin
      timer_nxt_s = timer_r;
      if (load_rfcnt) begin
         timer_nxt_s = rfc_val;
      end else if (!enable_s) begin
         timer_nxt_s = RFC_ZERO;
      end else if (tick_s || (timer_r == RFC_ZERO)) begin
         timer_nxt_s = interval_r;
      end else begin
         timer_nxt_s = timer_r - RFC_ONE;
      end
   end

   // Next pending count: saturate on ticks, never underflow on acks
   always_comb begin
      pend_nxt_s = pend_r;
      case ({tick_s, ref_ack})
         2'b10: begin
            if (pend_r == PEND_MAX) pend_nxt_s = pend_r;
            else                    pend_nxt_s = pend_r + PEND_ONE;
         end
         2'b01: begin
            if (pend_r == PEND_ZERO) pend_nxt_s = pend_r;
            else                     pend_nxt_s = pend_r - PEND_ONE;
         end
         2'b11: begin
            if (pend_r == PEND_ZERO) pend_nxt_s = PEND_ONE;
            else                     pend_nxt_s = pend_r;
         end
         default: pend_nxt_s = pend_r;
      endcase
   end

   // Interval, timer, pending count and flags; flags follow the new count
   always_ff @(posedge clk0 or negedge reset) begin
      if (!reset) begin
         interval_r <= RFC_ZERO;
         timer_r    <= RFC_ZERO;
         pend_r     <= PEND_ZERO;
         req_r      <= 1'b0;
         urgent_r   <= 1'b0;
      end else begin
         if (load_rfcnt) interval_r <= rfc_val;
         timer_r  <= timer_nxt_s;
         pend_r   <= pend_nxt_s;
         req_r    <= (pend_nxt_s != PEND_ZERO);
         urgent_r <= (pend_nxt_s == PEND_MAX);
      end
   end

   assign refresh_count = interval_r;
   assign ref_pend      = pend_r;
   assign ref_req       = req_r;
   assign ref_urgent    = urgent_r;

endmodule

// File: rtl/sdram_cfg_regs.sv
// SDRAM timing/refresh configuration bank: per-chip-select shadow and
// active timing sets with atomic commit, a registered output mux and
// the refresh timer. PADD_SIZE must be >= 16 and 2^CS_W >= NUM_CS.
module sdram_cfg_regs
   import sdram_cfg_pkg::*;
#(
   parameter int PADD_SIZE = 24,
   parameter int NUM_CS    = 4,
   parameter int CS_W      = 2,
   parameter int RFC_W     = 16,
   parameter int MAX_PEND  = 8,
   parameter int PEND_W    = 4
) (
   input  logic               clk0,
   input  logic               reset,
   input  logic [CS_W-1:0]    cs_act,
   sdram_cfg_regs_if.slave    bus,
   output logic [CAS_W-1:0]   cas_lat,
   output logic [RC_W-1:0]    ras_cas,
   output logic [REFD_W-1:0]  ref_dur,
   output logic               page_mod,
   output logic [BURST_W-1:0] bur_len,
   output logic [RFC_W-1:0]   refresh_count
);

   localparam logic [CS_W:0] NUM_CS_L = (CS_W+1)'(NUM_CS);

   timing_set_t     shadow_r [NUM_CS];
   timing_set_t     active_r [NUM_CS];
   timing_set_t     out_r;
   timing_set_t     new_set_s;
   logic            cs_act_ok_s;
   logic [CS_W-1:0] act_idx_s;
   logic            caddr_unused_s;

   assign new_set_s      = decode_timing(bus.caddr[FIELD_MSB:0]);
   assign cs_act_ok_s    = ({1'b0, cs_act} < NUM_CS_L);
   assign caddr_unused_s = ^bus.caddr;

   // Out-of-range active selects fall back to set 0
   always_comb begin
      act_idx_s = {CS_W{1'b0}};
      if (cs_act_ok_s) act_idx_s = cs_act;
      else             act_idx_s = {CS_W{1'b0}};
   end

   // Shadow write; a cs_sel matching no set drops the write
   always_ff @(posedge clk0 or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_CS; i++) shadow_r[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_CS; i++) begin
            if (bus.load_time && (bus.cs_sel == CS_W'(i))) shadow_r[i] <= new_set_s;
         end
      end
   end

   // Commit copies every shadow set at once, using pre-edge shadow values
   always_ff @(posedge clk0 or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_CS; i++) active_r[i] <= '0;
      end else if (bus.commit) begin
         for (int i = 0; i < NUM_CS; i++) active_r[i] <= shadow_r[i];
      end
   end

   // Registered view of the selected active set
   always_ff @(posedge clk0 or negedge reset) begin
      if (!reset) out_r <= '0;
      else        out_r <= active_r[act_idx_s];
   end

   assign cas_lat  = out_r.cas_lat;
   assign ras_cas  = out_r.ras_cas;
   assign ref_dur  = out_r.ref_dur;
   assign page_mod = out_r.page_mod;
   assign bur_len  = out_r.bur_len;

   sdram_ref_timer #(
      .RFC_W    (RFC_W),
      .MAX_PEND (MAX_PEND),
      .PEND_W   (PEND_W)
   ) u_ref_timer (
      .clk0          (clk0),
      .reset         (reset),
      .load_rfcnt    (bus.load_rfcnt),
      .rfc_val       (bus.caddr[RFC_W-1:0]),
      .ref_ack       (bus.ref_ack),
      .refresh_count (refresh_count),
      .ref_req       (bus.ref_req),
      .ref_urgent    (bus.ref_urgent),
      .ref_pend      (bus.ref_pend)
   );

endmodule

// File: doc/sdram_cfg_regs.md
Name: sdram_cfg_regs

Overview:
Parametrised timing/refresh configuration register bank for the SDRAM controller.
- Holds one timing set (CAS latency, RAS-to-CAS, refresh duration, page mode, burst length) per chip-select, in a shadow/active pair.
- Shadow-to-active updates happen atomically on a commit strobe.
- Adds a programmable refresh-interval timer with a postponed-refresh pending counter and a req/ack handshake toward the command sequencer.

Parameters:
- PADD_SIZE, 24: width of caddr config bus; must be at least 16.
- NUM_CS, 4: number of chip-selects / timing sets.
- CS_W, 2: width of chip-select indices; must satisfy 2^CS_W >= NUM_CS.
- RFC_W, 16: width of refresh interval and timer.
- MAX_PEND, 8: maximum queued (postponed) refreshes, 1..2^PEND_W-1.
- PEND_W, 4: width of pending counter.

Ports:
- clk0  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- load_time  in  1  write caddr timing fields into shadow set cs_sel.
- load_rfcnt  in  1  load refresh interval from caddr[RFC_W-1:0].
- commit  in  1  copy all shadow sets to active sets.
- cs_sel  in  CS_W  shadow set written by load_time.
- cs_act  in  CS_W  active set presented on timing outputs.
- caddr  in  PADD_SIZE  config data bus.
- ref_ack  in  1  sequencer has issued one auto-refresh.
- cas_lat  out  2  active[cs_act] CAS latency (registered).
- ras_cas  out  2  active[cs_act] RAS-to-CAS delay (registered).
- ref_dur  out  4  active[cs_act] refresh duration (registered).
- page_mod  out  1  active[cs_act] page mode (registered).
- bur_len  out  4  active[cs_act] burst length (registered).
- refresh_count  out  RFC_W  programmed refresh interval.
- ref_req  out  1  pending refreshes non-zero.
- ref_urgent  out  1  pending == MAX_PEND.
- ref_pend  out  PEND_W  pending refresh count.

Behaviour:
- Reset (reset low, async): all shadow sets, active sets, timing outputs, refresh_count, timer, pending, ref_req and ref_urgent are 0.
- Field map on load_time:
  - cas_lat = caddr[1:0], ras_cas = caddr[3:2], ref_dur = caddr[7:4], page_mod = caddr[8], bur_len = caddr[12:9].
  - caddr bits above 12 are ignored.
- load_time: shadow[cs_sel] updated next edge. cs_sel >= NUM_CS: write dropped, no state changes.
- commit: active[i] <= shadow[i] for all i, same edge.
  - load_time and commit in the same cycle: active takes the OLD shadow value; shadow takes the new value.
- Timing outputs:
  - Registered mux of active[cs_act]; 1-cycle latency after a cs_act change or commit.
  - cs_act >= NUM_CS drives set 0.
- Refresh timer (down-counter, RFC_W bits):
  - refresh_count == 0: timer disabled, held at 0, no ticks.
  - load_rfcnt: refresh_count and timer <= caddr[RFC_W-1:0] next edge. This discards any partial interval; pending is unaffected.
  - Enabled and timer == 1: tick is asserted, timer reloads refresh_count. Otherwise the timer decrements. This gives exactly one tick every refresh_count cycles.
  - load_rfcnt in the same cycle as a tick: the tick still counts; the reload uses the new value.
- Pending counter update per cycle, from tick and ref_ack:
  - tick only: +1, saturating at MAX_PEND. A tick at saturation is lost.
  - ack only: -1. Ack at 0 is ignored (no underflow).
  - both: unchanged. If pending == 0 in this case, the ack is ignored and the count goes to 1.
- Flags: ref_req = (pending != 0); ref_urgent = (pending == MAX_PEND). Both are registered, consistent with ref_pend in the same cycle.
- Reset mid-interval clears the timer and pending immediately. Refresh stays off until load_rfcnt.

Decomposition:
- Shared package sdram_cfg_pkg:
  - field widths CAS_W=2, RC_W=2, REFD_W=4, BURST_W=4;
  - caddr bit positions for each field;
  - a timing-set struct/typedef.
- One natural sub-module, sdram_ref_timer: timer, tick, pending counter, req/urgent flags. The register file and output mux stay in the top.

Test Plan:
- Reset, then load_time cs_sel=1 with caddr=0x1A5B, no commit, cs_act=1 -> outputs remain 0. Commit -> next cycle cas_lat=3, ras_cas=2, ref_dur=5, page_mod=0, bur_len=13.
- load_time cs_sel=2 with caddr=0x0011 in the same cycle as commit -> active[2] keeps its old value. A second commit -> cas_lat=1, ras_cas=0, ref_dur=1 with cs_act=2.
- load_rfcnt caddr=5, no ack -> ref_pend increments every 5 cycles, ref_req high after the first tick. Stops at 8 with ref_urgent=1, and extra ticks are lost.
- Pending=3, ref_ack asserted coincident with a tick -> ref_pend stays 3. Ack without a tick -> 2.
- Pending=0, ref_ack pulsed -> ref_pend stays 0. load_rfcnt caddr=0 -> no ticks for 100 cycles.
- Assert reset mid-interval with pending=4 -> all outputs 0 asynchronously. After release, no ticks until load_rfcnt.
